sparc_ifu_parseq: RTL and testbench
===================================

// Module: sparc_ifu_parseq
// PURPOSE
//  Sequences one shared 32b parity generator (odd number of ones => 1) across a
//  multi-word IFU data block, such as an I$ fill quad or a scrub read.
//  Serializes the words through the generator one per cycle and collects the
//  per-word parity bits. Optionally compares them against stored parity and
//  returns the result over a valid/ready response port.
//  The parity generator is instantiated outside this block: driven via par_in, sampled via par_out.
// PARAMETERS
//  NWORDS  4  number of 32b words per request (>=1)
//  TAGW    2  request tag width, returned unchanged with the response
// PORTS
//  rclk         in   1          clock; all state updates on posedge
//  reset        in   1          synchronous, active-high reset
//  req_vld      in   1          request valid
//  req_rdy      out  1          request ready; transfer when req_vld & req_rdy
//  req_data     in   32*NWORDS  data block; word i = req_data[32*i+31:32*i]
//  req_par      in   NWORDS     stored parity bits (bit i for word i)
//  req_chk      in   1          1 = compare against req_par; 0 = generate only
//  req_tag      in   TAGW       requester tag
//  par_in       out  32         word presented to the shared parity generator
//  par_out      in   1          generator result for par_in (combinational, same cycle)
//  rsp_vld      out  1          response valid
//  rsp_rdy      in   1          response accepted when rsp_vld & rsp_rdy
//  rsp_par      out  NWORDS     generated parity bits
//  rsp_errmask  out  NWORDS     per-word mismatch; all zero when the check is off
//  rsp_err      out  1          |rsp_errmask
//  rsp_tag      out  TAGW       captured req_tag
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  State machine:
//   - IDLE (req_rdy=1)
//       -> CALC on the req_vld handshake.
//       - On the handshake, capture req_data, req_par, req_chk and req_tag; clear cnt to 0.
//   - CALC
//       - par_in = word[cnt]; gen[cnt] <= par_out each cycle.
//       - cnt increments by 1.
//       - When cnt==NWORDS-1: go to RESP, and cnt wraps to 0.
//   - RESP (rsp_vld=1)
//       - Outputs are held stable until rsp_rdy.
//       - rsp_rdy -> IDLE.
//  Control and datapath rules:
//   - cnt width is max(1, $clog2(NWORDS)).
//   - NWORDS=1: exactly one CALC cycle.
//   - req_rdy=0 outside IDLE. No request is accepted in the same cycle a response retires.
//   - par_in = 32'h0 in IDLE and RESP.
//   - rsp_errmask = chk ? (gen ^ exp_par) : 0, registered/stable throughout RESP.
//  Timing:
//   - Handshake at edge T.
//   - CALC runs for cycles T+1 .. T+NWORDS.
//   - rsp_vld rises NWORDS+1 cycles after T.
//   - Minimum request spacing is NWORDS+2 cycles.
//  Reset values (outputs): req_rdy=1, busy=0, rsp_vld=0, rsp_par=0, rsp_errmask=0,
//   rsp_err=0, rsp_tag=0, par_in=0. Internal: cnt=0, gen=0, state=IDLE.
//  Boundary cases:
//   - reset mid-CALC or mid-RESP: the in-flight request is dropped with no response; next cycle is IDLE.
//   - reset has priority over any handshake in the same cycle.
//   - req_vld low in IDLE: state is held.
//   - Input changes while not in IDLE are ignored.
//   - rsp_rdy held low: RESP persists indefinitely and busy stays 1.
//   - rsp_rdy high before rsp_vld has no effect.
// TESTING
//  Common stimulus (NWORDS=4): req_data = {32'h80000000, 32'hFFFFFFFF, 32'h00000003, 32'h00000001}.
//  1. Common stimulus, req_chk=0, tag=2'd2, rsp_rdy=1
//     -> rsp_par=4'b1001, rsp_errmask=0, rsp_err=0, rsp_tag=2.
//     -> rsp_vld exactly 5 cycles after the handshake.
//  2. Same data, req_chk=1, req_par=4'b1001 -> rsp_err=0.
//     With req_par=4'b1011 -> rsp_errmask=4'b0010, rsp_err=1.
//  3. Sequencing: par_in shows 0x00000001, 0x00000003, 0xFFFFFFFF, 0x80000000 on consecutive CALC cycles.
//     par_in=0 elsewhere.
//  4. Backpressure: rsp_rdy=0 for 10 cycles -> rsp_* stable, req_rdy=0 and busy=1 throughout.
//     rsp_rdy=1 -> IDLE next cycle.
//  5. Reset asserted on the 2nd CALC cycle -> no rsp_vld ever for that request.
//     req_rdy=1 on the cycle after reset deasserts; a following request completes normally.
//  6. Back-to-back: req_vld held high with 3 requests and rsp_rdy=1
//     -> handshakes are spaced exactly 6 cycles apart; tags are returned in order.

Source files
------------

// File: rtl/sparc_ifu_parseq.sv
// Serializes a multi-word IFU block through one shared 32b parity generator,
// collects per-word parity, optionally checks it against stored parity, and returns a response.
module sparc_ifu_parseq #(
    parameter int NWORDS = 4,
    parameter int TAGW   = 2
) (
    input  logic                   rclk,
    input  logic                   reset,
    input  logic                   req_vld,
    output logic                   req_rdy,
    input  logic [32*NWORDS-1:0]   req_data,
    input  logic [NWORDS-1:0]      req_par,
    input  logic                   req_chk,
    input  logic [TAGW-1:0]        req_tag,
    output logic [31:0]            par_in,
    input  logic                   par_out,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [NWORDS-1:0]      rsp_par,
    output logic [NWORDS-1:0]      rsp_errmask,
    output logic                   rsp_err,
    output logic [TAGW-1:0]        rsp_tag,
    output logic                   busy
);

    localparam int CNTW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNTW-1:0]   cnt_reg;
    logic [NWORDS-1:0] gen_reg;
    logic [NWORDS-1:0] gen_next;
    logic [NWORDS-1:0] exp_par_reg;
    logic [NWORDS-1:0] errmask_reg;
    logic              chk_reg;
    logic [TAGW-1:0]   tag_reg;
    logic [31:0]       word_reg [NWORDS];
    logic              accept;

    assign accept = (state_reg == IDLE) && req_vld;

    // Word storage carries no reset: it is only read while CALC, after a capture.
    // gen_next drops the generator result into the slot selected by cnt.
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
        always_ff @(posedge rclk) begin
            if (accept) begin
                word_reg[gi] <= req_data[32*gi +: 32];
            end
        end

        assign gen_next[gi] = (state_reg == CALC && cnt_reg == CNTW'(gi)) ? par_out : gen_reg[gi];
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            gen_reg     <= '0;
            exp_par_reg <= '0;
            errmask_reg <= '0;
            chk_reg     <= 1'b0;
            tag_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_vld) begin
                        exp_par_reg <= req_par;
                        chk_reg     <= req_chk;
                        tag_reg     <= req_tag;
                        cnt_reg     <= '0;
                        state_reg   <= CALC;
                    end
                end
                CALC: begin
                    gen_reg <= gen_next;
                    if (cnt_reg == LAST) begin
                        // Mask is latched with the final bit so it stays frozen through RESP.
                        errmask_reg <= chk_reg ? (gen_next ^ exp_par_reg) : '0;
                        cnt_reg     <= '0;
                        state_reg   <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + CNTW'(1);
                    end
                end
                RESP: begin
                    if (rsp_rdy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_rdy     = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign rsp_vld     = (state_reg == RESP);
    assign par_in      = (state_reg == CALC) ? word_reg[cnt_reg] : 32'h0;
    assign rsp_par     = gen_reg;
    assign rsp_errmask = errmask_reg;
    assign rsp_err     = |errmask_reg;
    assign rsp_tag     = tag_reg;

endmodule

// File: tb/tb_sparc_ifu_parseq.sv
// Directed bench for sparc_ifu_parseq: models the external parity generator and
// checks sequencing, parity/check results, backpressure, reset and back-to-back requests.
module tb_sparc_ifu_parseq;

    logic         rclk = 1'b0;
    logic         reset;
    logic         req_vld;
    logic         req_rdy;
    logic [127:0] req_data;
    logic [3:0]   req_par;
    logic         req_chk;
    logic [1:0]   req_tag;
    logic [31:0]  par_in;
    logic         par_out;
    logic         rsp_vld;
    logic         rsp_rdy;
    logic [3:0]   rsp_par;
    logic [3:0]   rsp_errmask;
    logic         rsp_err;
    logic [1:0]   rsp_tag;
    logic         busy;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] COMMON = {32'h80000000, 32'hFFFFFFFF, 32'h00000003, 32'h00000001};
    localparam logic [127:0] ALT    = {32'h00000000, 32'h00000007, 32'h12345678, 32'hFFFFFFFE};

    always #5 rclk = ~rclk;

    // Shared odd-parity generator living outside the block.
    assign par_out = ^par_in;

    sparc_ifu_parseq #(.NWORDS(4), .TAGW(2)) dut (
        .rclk        (rclk),
        .reset       (reset),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_data    (req_data),
        .req_par     (req_par),
        .req_chk     (req_chk),
        .req_tag     (req_tag),
        .par_in      (par_in),
        .par_out     (par_out),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_par     (rsp_par),
        .rsp_errmask (rsp_errmask),
        .rsp_err     (rsp_err),
        .rsp_tag     (rsp_tag),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    // Issue one request from IDLE and walk it to RESP; returns with the response still presented.
    task automatic do_req(input logic [127:0] d, input logic [3:0] p, input logic c,
                          input logic [1:0] t, input logic [3:0] exp_par, input logic [3:0] exp_mask);
        req_data = d;
        req_par  = p;
        req_chk  = c;
        req_tag  = t;
        req_vld  = 1'b1;
        check("hs_req_rdy", 32'(req_rdy), 32'd1);
        tick;
        req_vld  = 1'b0;
        req_data = ~d;
        req_par  = ~p;
        req_chk  = ~c;
        req_tag  = ~t;
        for (int i = 0; i < 4; i++) begin
            check("calc_par_in", par_in, d[32*i +: 32]);
            check("calc_rsp_vld", 32'(rsp_vld), 32'd0);
            check("calc_busy", 32'(busy), 32'd1);
            check("calc_req_rdy", 32'(req_rdy), 32'd0);
            tick;
        end
        check("rsp_vld", 32'(rsp_vld), 32'd1);
        check("rsp_par", 32'(rsp_par), 32'(exp_par));
        check("rsp_errmask", 32'(rsp_errmask), 32'(exp_mask));
        check("rsp_err", 32'(rsp_err), 32'(|exp_mask));
        check("rsp_tag", 32'(rsp_tag), 32'(t));
        check("resp_par_in", par_in, 32'h0);
        check("resp_req_rdy", 32'(req_rdy), 32'd0);
        $display("REQ tag=%0d chk=%0d par=%b -> rsp_par=%b errmask=%b err=%0d",
                 t, c, p, rsp_par, rsp_errmask, rsp_err);
    endtask

    task automatic retire;
        rsp_rdy = 1'b1;
        tick;
        check("idle_req_rdy", 32'(req_rdy), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rsp_vld", 32'(rsp_vld), 32'd0);
        check("idle_par_in", par_in, 32'h0);
    endtask

    int hs_cyc [3];
    int hs_n;
    int rsp_n;
    int cyc;
    logic hs_now;

    initial begin
        reset    = 1'b1;
        req_vld  = 1'b0;
        req_data = '0;
        req_par  = '0;
        req_chk  = 1'b0;
        req_tag  = '0;
        rsp_rdy  = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        check("rst_req_rdy", 32'(req_rdy), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_par", 32'(rsp_par), 32'd0);
        check("rst_errmask", 32'(rsp_errmask), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_tag", 32'(rsp_tag), 32'd0);
        check("rst_par_in", par_in, 32'h0);

        // Idle with req_vld low holds state.
        tick;
        check("hold_busy", 32'(busy), 32'd0);

        // Generate only; rsp_rdy already high before rsp_vld.
        rsp_rdy = 1'b1;
        do_req(COMMON, 4'b0110, 1'b0, 2'd2, 4'b1001, 4'b0000);
        retire();

        do_req(COMMON, 4'b1001, 1'b1, 2'd1, 4'b1001, 4'b0000);
        retire();
        do_req(COMMON, 4'b1011, 1'b1, 2'd3, 4'b1001, 4'b0010);
        retire();
        do_req(ALT, 4'b0000, 1'b1, 2'd0, 4'b0111, 4'b0111);
        retire();

        // Backpressure, with a stray request that must be ignored.
        rsp_rdy = 1'b0;
        do_req(COMMON, 4'b1011, 1'b1, 2'd2, 4'b1001, 4'b0010);
        req_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("bp_rsp_vld", 32'(rsp_vld), 32'd1);
            check("bp_req_rdy", 32'(req_rdy), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_rsp_par", 32'(rsp_par), 32'b1001);
            check("bp_errmask", 32'(rsp_errmask), 32'b0010);
            check("bp_tag", 32'(rsp_tag), 32'd2);
        end
        req_vld = 1'b0;
        retire();

        // Reset on the second CALC cycle drops the request.
        req_data = COMMON;
        req_chk  = 1'b0;
        req_tag  = 2'd3;
        req_vld  = 1'b1;
        tick;
        req_vld = 1'b0;
        tick;
        check("rst2_calc_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rst2_req_rdy", 32'(req_rdy), 32'd1);
        check("rst2_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("rst2_no_rsp", 32'(rsp_vld), 32'd0);
            tick;
        end
        do_req(COMMON, 4'b1001, 1'b1, 2'd1, 4'b1001, 4'b0000);
        retire();

        // Reset wins over a handshake in the same cycle.
        req_vld = 1'b1;
        reset   = 1'b1;
        tick;
        reset   = 1'b0;
        req_vld = 1'b0;
        check("rstpri_busy", 32'(busy), 32'd0);
        check("rstpri_req_rdy", 32'(req_rdy), 32'd1);

        // Back-to-back requests with req_vld held high.
        req_data = COMMON;
        req_chk  = 1'b0;
        req_tag  = 2'd1;
        req_vld  = 1'b1;
        rsp_rdy  = 1'b1;
        hs_n  = 0;
        rsp_n = 0;
        cyc   = 0;
        while (cyc < 60 && rsp_n < 3) begin
            hs_now = 1'b0;
            if (req_vld && req_rdy && hs_n < 3) begin
                hs_cyc[hs_n] = cyc;
                hs_n++;
                hs_now = 1'b1;
            end
            if (rsp_vld && rsp_rdy) begin
                check("b2b_tag", 32'(rsp_tag), 32'(rsp_n + 1));
                $display("RSP b2b tag=%0d cycle=%0d", rsp_tag, cyc);
                rsp_n++;
            end
            tick;
            cyc++;
            if (hs_now) begin
                req_tag = 2'(hs_n + 1);
                if (hs_n == 3) req_vld = 1'b0;
            end
        end
        check("b2b_rsp_count", 32'(rsp_n), 32'd3);
        check("b2b_hs_count", 32'(hs_n), 32'd3);
        if (hs_n == 3) begin
            check("b2b_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd6);
            check("b2b_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
